// File: rtl/hs_cdc_gray_step_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hs_cdc_gray_step_ctrl_if
//  Purpose  : Target handshake plus counter/status bundle for the gray-step
//             controller. The master side issues targets and aborts; the
//             slave side (the controller) returns ready, counter and status.
//  Revision : 1.0 - initial release
// ============================================================================
interface hs_cdc_gray_step_ctrl_if #(
    parameter int WIDTH = 8
) ();

    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic             abort;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;

    // Requester side: drives targets and abort, observes progress
    modport master (
        output tgt_valid,
        output tgt_data,
        output abort,
        input  tgt_ready,
        input  cnt,
        input  busy,
        input  done
    );

    // Controller side
    modport slave (
        input  tgt_valid,
        input  tgt_data,
        input  abort,
        output tgt_ready,
        output cnt,
        output busy,
        output done
    );

endinterface
`default_nettype wire

// File: rtl/hs_cdc_gray_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hs_cdc_gray_step_ctrl
//  Purpose  : Source-domain sequencer feeding the binary input of a gray
//             multi-bit synchronizer. Walks a counter toward an accepted
//             target by +/-1 per step, holding HOLD_CYCLES after each step,
//             so the syncer only ever sees single-bit gray transitions.
//  Revision : 1.0 - initial release
// ============================================================================
module hs_cdc_gray_step_ctrl #(
    parameter int               WIDTH         = 8,
    parameter int               HOLD_CYCLES   = 0,
    parameter bit               WRAP_SHORTEST = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  wire                      clk,
    input  wire                      aresetn,
    hs_cdc_gray_step_ctrl_if.slave   bus
);

    // ------------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_STEP = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    localparam logic [7:0] c_HOLD_LOAD = 8'(HOLD_CYCLES);
    localparam bit         c_HAS_HOLD  = (HOLD_CYCLES > 0);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_tgt;
    logic             r_dir_up;
    logic [7:0]       r_hold_cnt;
    logic             r_done;
    logic             r_ready;
    logic             r_busy;

    // ------------------------------------------------------------------------
    // Next-value wires
    // ------------------------------------------------------------------------
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_tgt_nxt;
    logic             w_dir_up_nxt;
    logic [7:0]       w_hold_nxt;
    logic             w_done_nxt;
    logic             w_ready_nxt;
    logic             w_busy_nxt;

    // Helpers
    logic             w_handshake;
    logic             w_tgt_eq_cnt;
    logic [WIDTH-1:0] w_cnt_step;
    logic             w_step_hits;
    logic             w_dir_calc;

    assign w_handshake  = bus.tgt_valid & r_ready;
    assign w_tgt_eq_cnt = (bus.tgt_data == r_cnt);

    // Modular +/-1; in linear mode the target bounds the walk so no wrap occurs
    assign w_cnt_step  = r_dir_up ? (r_cnt + 1'b1) : (r_cnt - 1'b1);
    assign w_step_hits = (w_cnt_step == r_tgt);

    // ------------------------------------------------------------------------
    // Walk direction chosen once at acceptance and frozen for the whole walk
    // ------------------------------------------------------------------------
    generate
        if (WRAP_SHORTEST) begin : g_dir_wrap
            // Half the modulus; a distance equal to it (tie) walks up
            localparam logic [WIDTH-1:0] c_HALF = WIDTH'(64'd1 << (WIDTH - 1));
            logic [WIDTH-1:0] w_diff;
            assign w_diff     = bus.tgt_data - r_cnt;
            assign w_dir_calc = (w_diff <= c_HALF);
        end else begin : g_dir_linear
            assign w_dir_calc = (bus.tgt_data > r_cnt);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State and datapath registers, plus registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= RESET_VAL;
            r_tgt      <= RESET_VAL;
            r_dir_up   <= 1'b1;
            r_hold_cnt <= 8'd0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tgt      <= w_tgt_nxt;
            r_dir_up   <= w_dir_up_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_done     <= w_done_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath update logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_tgt_nxt    = r_tgt;
        w_dir_up_nxt = r_dir_up;
        w_hold_nxt   = r_hold_cnt;

        case (r_state)
            c_ST_IDLE: begin
                // abort is meaningless here and does not block acceptance
                if (w_handshake) begin
                    w_tgt_nxt = bus.tgt_data;
                    if (!w_tgt_eq_cnt) begin
                        w_state_nxt  = c_ST_STEP;
                        w_dir_up_nxt = w_dir_calc;
                    end
                end
            end

            c_ST_STEP: begin
                if (w_step_hits) begin
                    // Final step always completes, even alongside abort
                    w_cnt_nxt   = w_cnt_step;
                    w_state_nxt = c_ST_IDLE;
                end else if (bus.abort) begin
                    // Stop in place: counter keeps its current value
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_step;
                    if (c_HAS_HOLD) begin
                        w_state_nxt = c_ST_HOLD;
                        w_hold_nxt  = c_HOLD_LOAD;
                    end
                end
            end

            c_ST_HOLD: begin
                if (bus.abort) begin
                    w_state_nxt = c_ST_IDLE;
                    w_hold_nxt  = 8'd0;
                end else begin
                    w_hold_nxt = r_hold_cnt - 8'd1;
                    if (r_hold_cnt == 8'd1) begin
                        w_state_nxt = c_ST_STEP;
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_hold_nxt  = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output next-values: done on arrival, ready/busy track the next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_done_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b0;

        if ((r_state == c_ST_IDLE) && w_handshake && w_tgt_eq_cnt) begin
            w_done_nxt = 1'b1;
        end else if ((r_state == c_ST_STEP) && w_step_hits) begin
            w_done_nxt = 1'b1;
        end

        w_ready_nxt = (w_state_nxt == c_ST_IDLE);
        w_busy_nxt  = !w_ready_nxt;
    end

    // ------------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------------
    assign bus.cnt       = r_cnt;
    assign bus.tgt_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hs_cdc_gray_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hs_cdc_gray_step_ctrl
//  Purpose  : Directed self-checking bench for hs_cdc_gray_step_ctrl.
//             u0: WIDTH 8, HOLD 0, wrap, reset 0
//             u1: WIDTH 8, HOLD 0, linear, reset 250
//             u2: WIDTH 8, HOLD 2, wrap, reset 10
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hs_cdc_gray_step_ctrl;

    logic clk;
    logic aresetn;

    int n_vec;
    int n_err;
    bit mon_en;

    hs_cdc_gray_step_ctrl_if #(.WIDTH(8)) bus0 ();
    hs_cdc_gray_step_ctrl_if #(.WIDTH(8)) bus1 ();
    hs_cdc_gray_step_ctrl_if #(.WIDTH(8)) bus2 ();

    hs_cdc_gray_step_ctrl #(
        .WIDTH(8), .HOLD_CYCLES(0), .WRAP_SHORTEST(1'b1), .RESET_VAL(8'd0)
    ) u0 (
        .clk(clk), .aresetn(aresetn), .bus(bus0)
    );

    hs_cdc_gray_step_ctrl #(
        .WIDTH(8), .HOLD_CYCLES(0), .WRAP_SHORTEST(1'b0), .RESET_VAL(8'd250)
    ) u1 (
        .clk(clk), .aresetn(aresetn), .bus(bus1)
    );

    hs_cdc_gray_step_ctrl #(
        .WIDTH(8), .HOLD_CYCLES(2), .WRAP_SHORTEST(1'b1), .RESET_VAL(8'd10)
    ) u2 (
        .clk(clk), .aresetn(aresetn), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic hs0(input logic [7:0] d);
        bus0.tgt_data  = d;
        bus0.tgt_valid = 1'b1;
        tick();
        bus0.tgt_valid = 1'b0;
    endtask

    // Waits for done on u0; cyc counts edges after the accepting edge
    task automatic wait0(input int cyc0, input int budget, output int cyc);
        cyc = cyc0;
        while (bus0.done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("u0_done_seen", {31'd0, bus0.done}, 32'd1);
    endtask

    // Step-size and step-spacing invariant on every counter
    logic [7:0] p0, p1, p2;
    logic [7:0] d0, d1, d2;
    int         since2;
    always @(negedge clk) begin
        if (aresetn && mon_en) begin
            d0 = bus0.cnt - p0;
            d1 = bus1.cnt - p1;
            d2 = bus2.cnt - p2;
            n_vec += 3;
            assert (d0 == 8'd0 || d0 == 8'd1 || d0 == 8'hff) else begin
                n_err++;
                $error("FAIL u0_step_size: observed %0d required %0d+-1", bus0.cnt, p0);
            end
            assert (d1 == 8'd0 || d1 == 8'd1 || d1 == 8'hff) else begin
                n_err++;
                $error("FAIL u1_step_size: observed %0d required %0d+-1", bus1.cnt, p1);
            end
            assert (d2 == 8'd0 || d2 == 8'd1 || d2 == 8'hff) else begin
                n_err++;
                $error("FAIL u2_step_size: observed %0d required %0d+-1", bus2.cnt, p2);
            end
            if (d2 != 8'd0) begin
                n_vec++;
                assert (since2 >= 3) else begin
                    n_err++;
                    $error("FAIL u2_step_spacing: observed %0d cycles required >=3", since2);
                end
                since2 = 1;
            end else begin
                since2++;
            end
        end else begin
            since2 = 100;
        end
        p0 = bus0.cnt;
        p1 = bus1.cnt;
        p2 = bus2.cnt;
    end

    logic [7:0] exp2 [8] = '{8'd9, 8'd9, 8'd9, 8'd8, 8'd8, 8'd8, 8'd7, 8'd7};

    initial begin
        int  cyc;
        bit  seen_edge;
        n_vec  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        aresetn = 1'b0;
        bus0.tgt_valid = 1'b0; bus0.tgt_data = '0; bus0.abort = 1'b0;
        bus1.tgt_valid = 1'b0; bus1.tgt_data = '0; bus1.abort = 1'b0;
        bus2.tgt_valid = 1'b0; bus2.tgt_data = '0; bus2.abort = 1'b0;

        // ---- Reset state ----
        repeat (3) tick();
        chk("rst_u0_cnt",   {24'd0, bus0.cnt}, 32'd0);
        chk("rst_u0_ready", {31'd0, bus0.tgt_ready}, 32'd1);
        chk("rst_u0_busy",  {31'd0, bus0.busy}, 32'd0);
        chk("rst_u0_done",  {31'd0, bus0.done}, 32'd0);
        chk("rst_u1_cnt",   {24'd0, bus1.cnt}, 32'd250);
        chk("rst_u2_cnt",   {24'd0, bus2.cnt}, 32'd10);
        aresetn = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();

        // ---- u0: 0 -> 3, one step per edge ----
        hs0(8'd3);
        chk("t3_ready_k", {31'd0, bus0.tgt_ready}, 32'd0);
        chk("t3_busy_k",  {31'd0, bus0.busy}, 32'd1);
        chk("t3_cnt_k",   {24'd0, bus0.cnt}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t3_cnt",   {24'd0, bus0.cnt}, 32'(i));
            chk("t3_done",  {31'd0, bus0.done}, (i == 3) ? 32'd1 : 32'd0);
            chk("t3_ready", {31'd0, bus0.tgt_ready}, (i == 3) ? 32'd1 : 32'd0);
        end
        tick();
        chk("t3_done_drop", {31'd0, bus0.done}, 32'd0);

        // ---- u0: walk to 5, then request 5 again (equal target) ----
        hs0(8'd5);
        wait0(0, 10, cyc);
        chk("t5_steps", 32'(cyc), 32'd2);
        chk("t5_cnt",   {24'd0, bus0.cnt}, 32'd5);
        tick();
        hs0(8'd5);
        chk("eq_cnt",   {24'd0, bus0.cnt}, 32'd5);
        chk("eq_done",  {31'd0, bus0.done}, 32'd1);
        chk("eq_ready", {31'd0, bus0.tgt_ready}, 32'd1);
        chk("eq_busy",  {31'd0, bus0.busy}, 32'd0);
        tick();
        chk("eq_done_drop", {31'd0, bus0.done}, 32'd0);
        chk("eq_cnt_hold",  {24'd0, bus0.cnt}, 32'd5);

        // ---- u0: 5 -> 0 goes down (distance 251 > 128) ----
        hs0(8'd0);
        tick();
        chk("t0_first_down", {24'd0, bus0.cnt}, 32'd4);
        wait0(1, 10, cyc);
        chk("t0_steps", 32'(cyc), 32'd5);

        // ---- u0: tie 0 -> 128 walks up ----
        tick();
        hs0(8'd128);
        tick();
        chk("tie_first_up", {24'd0, bus0.cnt}, 32'd1);
        wait0(1, 200, cyc);
        chk("tie_steps", 32'(cyc), 32'd128);
        chk("tie_cnt",   {24'd0, bus0.cnt}, 32'd128);

        // ---- u0: 128 -> 250 (up, 122), then 250 -> 2 wraps up ----
        tick();
        hs0(8'd250);
        wait0(0, 200, cyc);
        chk("t250_steps", 32'(cyc), 32'd122);
        tick();
        hs0(8'd2);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("wrap_cnt",  {24'd0, bus0.cnt}, 32'((250 + i) % 256));
            chk("wrap_done", {31'd0, bus0.done}, (i == 8) ? 32'd1 : 32'd0);
        end

        // ---- u0: back to 0, then 0 -> 20 aborted at 6 ----
        tick();
        hs0(8'd0);
        wait0(0, 10, cyc);
        chk("t0b_steps", 32'(cyc), 32'd2);
        tick();
        hs0(8'd20);
        cyc = 0;
        while (bus0.cnt !== 8'd6 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("ab_reach6", {24'd0, bus0.cnt}, 32'd6);
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        chk("ab_cnt",   {24'd0, bus0.cnt}, 32'd6);
        chk("ab_done",  {31'd0, bus0.done}, 32'd0);
        chk("ab_ready", {31'd0, bus0.tgt_ready}, 32'd1);
        chk("ab_busy",  {31'd0, bus0.busy}, 32'd0);
        tick();
        chk("ab_cnt_stay", {24'd0, bus0.cnt}, 32'd6);
        chk("ab_no_done",  {31'd0, bus0.done}, 32'd0);

        // ---- u0: abort on the final step still completes with done ----
        hs0(8'd8);
        tick();
        chk("abf_cnt7", {24'd0, bus0.cnt}, 32'd7);
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        chk("abf_cnt",  {24'd0, bus0.cnt}, 32'd8);
        chk("abf_done", {31'd0, bus0.done}, 32'd1);

        // ---- u0: abort in IDLE does not block acceptance ----
        tick();
        bus0.abort = 1'b1;
        hs0(8'd9);
        bus0.abort = 1'b0;
        chk("abi_busy", {31'd0, bus0.busy}, 32'd1);
        tick();
        chk("abi_cnt",  {24'd0, bus0.cnt}, 32'd9);
        chk("abi_done", {31'd0, bus0.done}, 32'd1);

        // ---- u0: new handshake in the same cycle as done ----
        hs0(8'd11);
        chk("dh_busy", {31'd0, bus0.busy}, 32'd1);
        chk("dh_done", {31'd0, bus0.done}, 32'd0);
        tick();
        chk("dh_cnt10", {24'd0, bus0.cnt}, 32'd10);
        tick();
        chk("dh_cnt11", {24'd0, bus0.cnt}, 32'd11);
        chk("dh_done2", {31'd0, bus0.done}, 32'd1);

        // ---- u1 (linear): 250 -> 2 walks down 248 steps, never 255 or 0 ----
        bus1.tgt_data  = 8'd2;
        bus1.tgt_valid = 1'b1;
        tick();
        bus1.tgt_valid = 1'b0;
        tick();
        chk("lin_first_down", {24'd0, bus1.cnt}, 32'd249);
        cyc = 1;
        seen_edge = 1'b0;
        while (bus1.done !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
            if (bus1.cnt == 8'd255 || bus1.cnt == 8'd0) seen_edge = 1'b1;
        end
        chk("lin_done_seen", {31'd0, bus1.done}, 32'd1);
        chk("lin_steps",     32'(cyc), 32'd248);
        chk("lin_cnt",       {24'd0, bus1.cnt}, 32'd2);
        chk("lin_no_wrap",   {31'd0, seen_edge}, 32'd0);

        // ---- u2 (HOLD 2): 10 -> 7, a change every 3 cycles ----
        bus2.tgt_data  = 8'd7;
        bus2.tgt_valid = 1'b1;
        tick();
        bus2.tgt_valid = 1'b0;
        chk("hold_cnt_k", {24'd0, bus2.cnt}, 32'd10);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("hold_cnt",  {24'd0, bus2.cnt}, {24'd0, exp2[i]});
            chk("hold_done", {31'd0, bus2.done}, (i == 6) ? 32'd1 : 32'd0);
        end

        // ---- Reset mid-walk: immediate return to reset values ----
        hs0(8'd100);
        repeat (3) tick();
        chk("mr_walking", {24'd0, bus0.cnt}, 32'd14);
        mon_en = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        chk("mr_cnt",   {24'd0, bus0.cnt}, 32'd0);
        chk("mr_ready", {31'd0, bus0.tgt_ready}, 32'd1);
        chk("mr_busy",  {31'd0, bus0.busy}, 32'd0);
        chk("mr_done",  {31'd0, bus0.done}, 32'd0);
        chk("mr_u2cnt", {24'd0, bus2.cnt}, 32'd10);
        tick();
        aresetn = 1'b1;
        tick();
        chk("mr_after_cnt", {24'd0, bus0.cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
